// File: rtl/branch_predictor_gshare_pkg.sv
// Shared constants and counter helpers for the gshare fetch predictor.
// Latency: none (pure functions); no backpressure.
package branch_predictor_gshare_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Weakly-taken start value for a counter of the given width.
  function automatic logic [31:0] cnt_init(input int width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic logic [31:0] sat_update(input logic [31:0] cnt, input logic taken,
                                             input int width);
    logic [31:0] cnt_max;
    cnt_max = (32'd1 << width) - 32'd1;
    if (taken) begin
      return (cnt >= cnt_max) ? cnt_max : cnt + 32'd1;
    end
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_btb.sv
// Direct-mapped BTB: tag/target/valid arrays, async read, sync write, sync clear of valids.
// Latency: read 0 cycles, write visible next cycle (no bypass); no backpressure.
module bpred_btb
  import branch_predictor_gshare_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int IDX_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] rd_pc,
  output logic                 rd_hit,
  output logic [WORD_SIZE-1:0] rd_target,
  input  logic                 wr_en,
  input  logic [WORD_SIZE-1:0] wr_pc,
  input  logic [WORD_SIZE-1:0] wr_target
);

  localparam int ENTRIES = 1 << IDX_SIZE;
  localparam int TAG_W   = WORD_SIZE - IDX_SIZE;

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_d    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [WORD_SIZE-1:0] target_d [ENTRIES];
  logic [IDX_SIZE-1:0]  rd_idx, wr_idx;

  assign rd_idx    = rd_pc[IDX_SIZE-1:0];
  assign wr_idx    = wr_pc[IDX_SIZE-1:0];
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc[WORD_SIZE-1:IDX_SIZE]);
  assign rd_target = target_q[rd_idx];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_pc[WORD_SIZE-1:IDX_SIZE];
      target_d[wr_idx] = wr_target;
    end
  end

  // Only valids need clearing; stale tags/targets are unreachable once invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal next-PC predictor: BTB + saturating-counter PHT + speculative GHR.
// Latency: prediction 0 cycles, training visible next cycle; no backpressure (one resolve/cycle).
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int BTB_IDX_SIZE = 8,
  parameter int PHT_IDX_SIZE = 8,
  parameter int GHR_SIZE     = 8,
  parameter int CNT_WIDTH    = 2,
  parameter int MODE         = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic                 fetch_valid,
  output logic                 btb_hit,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] npc,
  output logic [GHR_SIZE-1:0]  pred_ghr,
  input  logic                 resolve_valid,
  input  logic [WORD_SIZE-1:0] resolve_pc,
  input  logic [GHR_SIZE-1:0]  resolve_ghr,
  input  logic                 resolve_taken,
  input  logic [WORD_SIZE-1:0] resolve_target,
  input  logic                 resolve_mispred
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_SIZE;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(cnt_init(CNT_WIDTH));

  if (GHR_SIZE < 1 || GHR_SIZE > PHT_IDX_SIZE || CNT_WIDTH < 1 || CNT_WIDTH > 31 ||
      BTB_IDX_SIZE < 1 || BTB_IDX_SIZE >= WORD_SIZE || PHT_IDX_SIZE > WORD_SIZE ||
      (MODE != MODE_BIMODAL && MODE != MODE_GSHARE)) begin : g_bad_params
    $fatal(1, "branch_predictor_gshare: illegal parameter combination");
  end

  logic [GHR_SIZE-1:0]     ghr_q, ghr_d;
  logic [CNT_WIDTH-1:0]    pht_q [PHT_ENTRIES];
  logic [CNT_WIDTH-1:0]    pht_d [PHT_ENTRIES];
  logic [PHT_IDX_SIZE-1:0] pidx, ridx;
  logic [WORD_SIZE-1:0]    btb_target;

  assign pidx = pc[PHT_IDX_SIZE-1:0] ^
                ((MODE == MODE_GSHARE) ? PHT_IDX_SIZE'(ghr_q) : '0);
  assign ridx = resolve_pc[PHT_IDX_SIZE-1:0] ^
                ((MODE == MODE_GSHARE) ? PHT_IDX_SIZE'(resolve_ghr) : '0);

  bpred_btb #(
    .WORD_SIZE(WORD_SIZE),
    .IDX_SIZE (BTB_IDX_SIZE)
  ) u_btb (
    .clk      (clk),
    .reset    (reset),
    .rd_pc    (pc),
    .rd_hit   (btb_hit),
    .rd_target(btb_target),
    .wr_en    (resolve_valid && resolve_taken),
    .wr_pc    (resolve_pc),
    .wr_target(resolve_target)
  );

  assign pred_taken = btb_hit && pht_q[pidx][CNT_WIDTH-1];
  assign npc        = pred_taken ? btb_target : pc + WORD_SIZE'(1);
  assign pred_ghr   = ghr_q;

  // A mispredict rebuilds history from the branch's checkpoint; same-cycle fetch is wrong-path.
  always_comb begin
    ghr_d = ghr_q;
    if (resolve_valid && resolve_mispred) begin
      ghr_d = GHR_SIZE'({resolve_ghr, resolve_taken});
    end else if (fetch_valid && btb_hit) begin
      ghr_d = GHR_SIZE'({ghr_q, pred_taken});
    end
    pht_d = pht_q;
    if (resolve_valid) begin
      pht_d[ridx] = CNT_WIDTH'(sat_update(32'(pht_q[ridx]), resolve_taken, CNT_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CNT_INIT;
      end
    end else begin
      ghr_q <= ghr_d;
      pht_q <= pht_d;
    end
  end

endmodule
